// File: rtl/stump_mem_arbiter_pkg.sv
// rtl/stump_mem_arbiter_pkg.sv - shared types and constants for the Stump memory arbiter
package stump_mem_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 3;

    // Arbiter FSM encoding
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACCESS = 1'b1
    } arb_state_t;

    // Owner encoding: which requester holds (or last held) the memory
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/stump_mem_arbiter_if.sv
// rtl/stump_mem_arbiter_if.sv - core, DMA and memory bus bundle for the Stump memory arbiter
interface stump_mem_arbiter_if;
    import stump_mem_arbiter_pkg::*;

    // Core side
    logic              cpu_req;
    logic              cpu_wen;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_done;
    logic              cpu_stall;

    // DMA / debug side
    logic              dma_req;
    logic              dma_wen;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_done;

    // Memory side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ren;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_rdata;

    logic              owner;

    // Arbiter view
    modport slave (
        input  cpu_req, cpu_wen, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done, cpu_stall,
        input  dma_req, dma_wen, dma_addr, dma_wdata,
        output dma_rdata, dma_done,
        output mem_addr, mem_wdata, mem_ren, mem_wen,
        input  mem_rdata,
        output owner
    );

    // Requester / memory-model view
    modport master (
        output cpu_req, cpu_wen, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done, cpu_stall,
        output dma_req, dma_wen, dma_addr, dma_wdata,
        input  dma_rdata, dma_done,
        input  mem_addr, mem_wdata, mem_ren, mem_wen,
        output mem_rdata,
        input  owner
    );

endinterface

// File: rtl/stump_rr_pick.sv
// rtl/stump_rr_pick.sv - combinational two-way round-robin pick
module stump_rr_pick (
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_last,
    output logic o_grant_valid,
    output logic o_grant_id
);

    // A lone requester wins outright; on a tie the side that did not go last wins
    always_comb begin
        o_grant_valid = i_req_a | i_req_b;
        if (i_req_a && i_req_b) begin
            o_grant_id = ~i_last;
        end else begin
            o_grant_id = i_req_b;
        end
    end

endmodule

// File: rtl/stump_mem_arbiter.sv
// rtl/stump_mem_arbiter.sv - serialises core and DMA accesses onto the single-ported Stump memory
module stump_mem_arbiter
    import stump_mem_arbiter_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    stump_mem_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);

    arb_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_owner;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_ren;
    logic              r_mem_wen;
    logic              r_cpu_done;
    logic              r_dma_done;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dma_rdata;

    logic              w_elig_cpu;
    logic              w_elig_dma;
    logic              w_grant_valid;
    logic              w_grant_id;
    logic              w_req_wen;
    logic [ADDR_W-1:0] w_req_addr;
    logic [DATA_W-1:0] w_req_wdata;

    // A side that completes this cycle sits out one arbitration so the other can get in
    assign w_elig_cpu = bus.cpu_req & ~r_cpu_done;
    assign w_elig_dma = bus.dma_req & ~r_dma_done;

    stump_rr_pick u_pick (
        .i_req_a       (w_elig_cpu),
        .i_req_b       (w_elig_dma),
        .i_last        (r_owner),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    // Request fields of whichever side the picker chose
    always_comb begin
        w_req_wen   = bus.cpu_wen;
        w_req_addr  = bus.cpu_addr;
        w_req_wdata = bus.cpu_wdata;
        if (w_grant_id == OWN_DMA) begin
            w_req_wen   = bus.dma_wen;
            w_req_addr  = bus.dma_addr;
            w_req_wdata = bus.dma_wdata;
        end
    end

    // Arbitration FSM: grant in IDLE, hold the bus for WAIT_STATES+1 cycles, then pulse done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_cnt       <= '0;
            r_owner     <= OWN_DMA;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_ren   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_cpu_done  <= 1'b0;
            r_dma_done  <= 1'b0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            r_cpu_done <= 1'b0;
            r_dma_done <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant_valid) begin
                        r_owner     <= w_grant_id;
                        r_mem_addr  <= w_req_addr;
                        r_mem_wdata <= w_req_wdata;
                        r_mem_ren   <= ~w_req_wen;
                        r_mem_wen   <= w_req_wen;
                        r_cnt       <= WS_LOAD;
                        r_state     <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        if (r_owner == OWN_CPU) begin
                            r_cpu_done <= 1'b1;
                            if (r_mem_ren) begin
                                r_cpu_rdata <= bus.mem_rdata;
                            end
                        end else begin
                            r_dma_done <= 1'b1;
                            if (r_mem_ren) begin
                                r_dma_rdata <= bus.mem_rdata;
                            end
                        end
                        r_mem_ren <= 1'b0;
                        r_mem_wen <= 1'b0;
                        r_state   <= ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_ren   = r_mem_ren;
    assign bus.mem_wen   = r_mem_wen;
    assign bus.cpu_done  = r_cpu_done;
    assign bus.dma_done  = r_dma_done;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.dma_rdata = r_dma_rdata;
    assign bus.owner     = r_owner;
    assign bus.cpu_stall = bus.cpu_req & ~r_cpu_done;

endmodule

// File: tb/tb_stump_mem_arbiter.sv
// tb/tb_stump_mem_arbiter.sv - scoreboard bench for stump_mem_arbiter
module tb_stump_mem_arbiter;
    import stump_mem_arbiter_pkg::*;

    typedef struct {
        logic        side;
        logic        is_read;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a;
    exp_t e_b;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    logic [15:0] wr_b [logic [15:0]];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stump_mem_arbiter_if bus_a ();
    stump_mem_arbiter_if bus_b ();

    stump_mem_arbiter #(.WAIT_STATES(0)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .bus   (bus_a)
    );

    stump_mem_arbiter #(.WAIT_STATES(3)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .bus   (bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'hC3C3);
    endfunction

    // Memory models: rdata settles mid-cycle from the registered address
    always @(negedge clk) begin
        bus_a.mem_rdata = init_val(bus_a.mem_addr);
        if (bus_b.mem_wen) wr_b[bus_b.mem_addr] = bus_b.mem_wdata;
        bus_b.mem_rdata = wr_b.exists(bus_b.mem_addr) ? wr_b[bus_b.mem_addr] : init_val(bus_b.mem_addr);
    end

    // Scoreboard monitor, instance A
    always @(negedge clk) begin
        if (rst_a) begin
            chk("a_ren_wen_excl", {31'b0, bus_a.mem_ren & bus_a.mem_wen}, 32'd0);
            if (bus_a.cpu_done || bus_a.dma_done) begin
                if (q_a.size() == 0) begin
                    chk("a_spurious_done_qsize", q_a.size(), 32'd1);
                end else begin
                    e_a = q_a.pop_front();
                    chk("a_done_side", {30'b0, bus_a.dma_done, bus_a.cpu_done}, e_a.side ? 32'd2 : 32'd1);
                    chk("a_done_cycle", cyc, e_a.cyc);
                    if (e_a.is_read)
                        chk("a_rdata", e_a.side ? {16'b0, bus_a.dma_rdata} : {16'b0, bus_a.cpu_rdata}, {16'b0, e_a.data});
                end
            end
        end
    end

    // Scoreboard monitor, instance B
    always @(negedge clk) begin
        if (rst_b) begin
            chk("b_ren_wen_excl", {31'b0, bus_b.mem_ren & bus_b.mem_wen}, 32'd0);
            if (bus_b.cpu_done || bus_b.dma_done) begin
                if (q_b.size() == 0) begin
                    chk("b_spurious_done_qsize", q_b.size(), 32'd1);
                end else begin
                    e_b = q_b.pop_front();
                    chk("b_done_side", {30'b0, bus_b.dma_done, bus_b.cpu_done}, e_b.side ? 32'd2 : 32'd1);
                    chk("b_done_cycle", cyc, e_b.cyc);
                    if (e_b.is_read)
                        chk("b_rdata", e_b.side ? {16'b0, bus_b.dma_rdata} : {16'b0, bus_b.cpu_rdata}, {16'b0, e_b.data});
                end
            end
        end
    end

    initial begin
        int c;
        int n_stall;
        int n_ren;
        int n_wen;

        bus_a.cpu_req = 0; bus_a.cpu_wen = 0; bus_a.cpu_addr = 0; bus_a.cpu_wdata = 0;
        bus_a.dma_req = 0; bus_a.dma_wen = 0; bus_a.dma_addr = 0; bus_a.dma_wdata = 0;
        bus_b.cpu_req = 0; bus_b.cpu_wen = 0; bus_b.cpu_addr = 0; bus_b.cpu_wdata = 0;
        bus_b.dma_req = 0; bus_b.dma_wen = 0; bus_b.dma_addr = 0; bus_b.dma_wdata = 0;

        // Asynchronous reset, checked before any clock edge
        #1 rst_a = 0; rst_b = 0;
        #1;
        chk("rst_mem_ren", {31'b0, bus_a.mem_ren}, 32'd0);
        chk("rst_mem_wen", {31'b0, bus_a.mem_wen}, 32'd0);
        chk("rst_mem_addr", {16'b0, bus_a.mem_addr}, 32'd0);
        chk("rst_mem_wdata", {16'b0, bus_a.mem_wdata}, 32'd0);
        chk("rst_done", {30'b0, bus_a.cpu_done, bus_a.dma_done}, 32'd0);
        chk("rst_cpu_rdata", {16'b0, bus_a.cpu_rdata}, 32'd0);
        chk("rst_dma_rdata", {16'b0, bus_a.dma_rdata}, 32'd0);
        chk("rst_owner", {31'b0, bus_a.owner}, 32'd1);
        chk("rst_owner_b", {31'b0, bus_b.owner}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_a = 1; rst_b = 1;

        // Core read of 0x0010, no wait states
        @(posedge clk); #1;
        c = cyc;
        bus_a.cpu_req = 1; bus_a.cpu_wen = 0; bus_a.cpu_addr = 16'h0010;
        q_a.push_back('{side: 1'b0, is_read: 1'b1, data: 16'hBEEF, cyc: c + 2});
        n_stall = 0; n_ren = 0;
        repeat (3) begin
            @(negedge clk);
            n_stall += int'(bus_a.cpu_stall);
            n_ren   += int'(bus_a.mem_ren);
            @(posedge clk); #1;
        end
        bus_a.cpu_req = 0;
        chk("t1_stall_cycles", n_stall, 32'd2);
        chk("t1_ren_cycles", n_ren, 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // Both sides requesting continuously from reset: grants alternate core, DMA, ...
        rst_a = 0;
        @(posedge clk); #1;
        bus_a.cpu_req = 1; bus_a.cpu_wen = 0; bus_a.cpu_addr = 16'h0020;
        bus_a.dma_req = 1; bus_a.dma_wen = 0; bus_a.dma_addr = 16'h0030;
        rst_a = 1;
        c = cyc;
        for (int k = 0; k < 7; k++) begin
            q_a.push_back('{side: k[0], is_read: 1'b1,
                            data: init_val(k[0] ? 16'h0030 : 16'h0020), cyc: c + 2 + 2 * k});
        end
        repeat (13) @(posedge clk);
        #1;
        // Core is mid-access here; dropping req must not cancel it
        bus_a.cpu_req = 0; bus_a.dma_req = 0;
        repeat (3) @(posedge clk);
        #1;

        // Core alone, continuous: one access every three cycles
        c = cyc;
        bus_a.cpu_req = 1; bus_a.cpu_wen = 0; bus_a.cpu_addr = 16'h0040;
        for (int k = 0; k < 3; k++)
            q_a.push_back('{side: 1'b0, is_read: 1'b1, data: init_val(16'h0040), cyc: c + 2 + 3 * k});
        n_ren = 0;
        repeat (9) begin
            @(negedge clk);
            n_ren += int'(bus_a.mem_ren);
            @(posedge clk); #1;
        end
        bus_a.cpu_req = 0;
        chk("t3_ren_cycles", n_ren, 32'd3);
        chk("t3_owner", {31'b0, bus_a.owner}, 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // DMA write with three wait states
        c = cyc;
        bus_b.dma_req = 1; bus_b.dma_wen = 1; bus_b.dma_addr = 16'h8000; bus_b.dma_wdata = 16'h1234;
        q_b.push_back('{side: 1'b1, is_read: 1'b0, data: 16'h0000, cyc: c + 5});
        n_wen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus_b.mem_wen) begin
                n_wen++;
                chk("b1_wr_addr", {16'b0, bus_b.mem_addr}, 32'h8000);
                chk("b1_wr_data", {16'b0, bus_b.mem_wdata}, 32'h1234);
            end
            @(posedge clk); #1;
        end
        bus_b.dma_req = 0;
        chk("b1_wen_cycles", n_wen, 32'd4);
        chk("b1_dma_rdata_kept", {16'b0, bus_b.dma_rdata}, 32'd0);
        chk("b1_cpu_rdata_kept", {16'b0, bus_b.cpu_rdata}, 32'd0);
        @(posedge clk); #1;

        // DMA read-back, req dropped in the second access cycle
        c = cyc;
        bus_b.dma_req = 1; bus_b.dma_wen = 0; bus_b.dma_addr = 16'h8000;
        q_b.push_back('{side: 1'b1, is_read: 1'b1, data: 16'h1234, cyc: c + 5});
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_b.dma_req = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("b2_no_regrant", {31'b0, bus_b.mem_ren}, 32'd0);

        // Reset in the second access cycle aborts the core read
        bus_b.cpu_req = 1; bus_b.cpu_wen = 0; bus_b.cpu_addr = 16'h0010;
        @(posedge clk); #1;
        chk("b3_ren_before_rst", {31'b0, bus_b.mem_ren}, 32'd1);
        @(posedge clk); #1;
        rst_b = 0;
        bus_b.cpu_req = 0;
        #1;
        chk("b3_ren_at_rst", {31'b0, bus_b.mem_ren}, 32'd0);
        chk("b3_owner_at_rst", {31'b0, bus_b.owner}, 32'd1);
        chk("b3_done_at_rst", {31'b0, bus_b.cpu_done}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_b = 1;
        repeat (6) @(posedge clk);
        #1;
        c = cyc;
        bus_b.cpu_req = 1; bus_b.cpu_wen = 0; bus_b.cpu_addr = 16'h0010;
        q_b.push_back('{side: 1'b0, is_read: 1'b1, data: 16'hBEEF, cyc: c + 5});
        repeat (6) @(posedge clk);
        #1;
        bus_b.cpu_req = 0;
        repeat (3) @(posedge clk);
        #1;

        chk("a_queue_drained", q_a.size(), 32'd0);
        chk("b_queue_drained", q_b.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
